// File: rtl/shape_processor_modeling_pkg.sv
// Shared shape processor modelling types: CTRL SFR layout, SHAPE/OPERATION
// encodings and the legality helpers used by the CTRL write path.
package shape_processor_modeling;

    typedef enum logic [1:0] {
        SHAPE_ILLEGAL = 2'b00,
        RECTANGLE     = 2'b01,
        TRIANGLE      = 2'b10,
        KEEP_SHAPE    = 2'b11
    } shape_e;

    typedef enum logic [5:0] {
        PERIMETER      = 6'h00,
        AREA           = 6'h01,
        IS_SQUARE      = 6'h10,
        IS_EQUILATERAL = 6'h20,
        IS_ISOSCELES   = 6'h21,
        KEEP_OPERATION = 6'h3F
    } operation_e;

    typedef struct packed {
        logic [13:0] reserved_hi;
        shape_e      shape;
        logic [9:0]  reserved_lo;
        operation_e  operation;
    } ctrl_sfr_reg;

    // Any SHAPE field value except 'b00 is a meaningful encoding (KEEP included).
    function automatic logic is_legal_shape(input logic [1:0] s);
        return s != SHAPE_ILLEGAL;
    endfunction

    // Only the listed operations plus KEEP_OPERATION are meaningful encodings.
    function automatic logic is_legal_operation(input logic [5:0] o);
        logic legal;
        legal = 1'b0;
        case (o)
            PERIMETER, AREA, IS_SQUARE,
            IS_EQUILATERAL, IS_ISOSCELES,
            KEEP_OPERATION: legal = 1'b1;
            default:        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Combination check on already-resolved (non-KEEP) shape and operation.
    function automatic logic is_legal_combination(input logic [1:0] s, input logic [5:0] o);
        logic legal;
        legal = 1'b0;
        case (o)
            PERIMETER, AREA: legal = (s == RECTANGLE) || (s == TRIANGLE);
            IS_SQUARE:       legal = (s == RECTANGLE);
            IS_EQUILATERAL,
            IS_ISOSCELES:    legal = (s == TRIANGLE);
            default:         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shape_processor_ctrl_resolve.sv
// Combinational resolution of a CTRL write: substitutes the KEEP codes with
// the current values and decides whether the whole write must be rejected.
module shape_processor_ctrl_resolve
    import shape_processor_modeling::*;
(
    input  logic [1:0] old_shape,
    input  logic [5:0] old_operation,
    input  logic [1:0] shape_field,
    input  logic [5:0] operation_field,
    output logic [1:0] new_shape,
    output logic [5:0] new_operation,
    output logic       reject
);

    // Resolve KEEP codes, then reject on a bad encoding or a bad pairing.
    always_comb begin
        new_shape     = (shape_field == KEEP_SHAPE) ? old_shape : shape_field;
        new_operation = (operation_field == KEEP_OPERATION) ? old_operation : operation_field;
        reject        = !is_legal_shape(shape_field)
                     || !is_legal_operation(operation_field)
                     || !is_legal_combination(new_shape, new_operation);
    end

endmodule

// File: rtl/shape_processor_ctrl_sfr.sv
// CTRL SFR responder: accepts one write at a time, checks it for one cycle,
// then holds an OK/ERROR response until consumed. Reads are served every
// cycle independently of the write FSM.
module shape_processor_ctrl_sfr
    import shape_processor_modeling::*;
#(
    parameter int unsigned ERR_CNT_WIDTH   = 8,
    parameter shape_e      RESET_SHAPE     = RECTANGLE,
    parameter operation_e  RESET_OPERATION = PERIMETER
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_valid,
    output logic                     write_ready,
    input  logic [31:0]              write_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_error,
    input  logic                     read_valid,
    output logic                     read_data_valid,
    output logic [31:0]              read_data,
    output logic [1:0]               shape,
    output logic [5:0]               operation,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } ctrl_state_e;

    ctrl_state_e state;
    ctrl_state_e state_next;

    logic [1:0]  shape_q;
    logic [5:0]  operation_q;
    logic [1:0]  pend_shape_field;
    logic [5:0]  pend_operation_field;
    logic [1:0]  new_shape;
    logic [5:0]  new_operation;
    logic        reject;
    ctrl_sfr_reg ctrl_word;

    // Reserved CTRL bits carry no meaning; this only documents that they are dropped.
    logic unused_reserved;
    assign unused_reserved = ^{write_data[31:18], write_data[15:6]};

    shape_processor_ctrl_resolve u_resolve (
        .old_shape       (shape_q),
        .old_operation   (operation_q),
        .shape_field     (pend_shape_field),
        .operation_field (pend_operation_field),
        .new_shape       (new_shape),
        .new_operation   (new_operation),
        .reject          (reject)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state: IDLE -> CHECK on a write, one CHECK cycle, RESP until consumed.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (write_valid) state_next = CHECK;
            CHECK:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, response shown for the whole RESP state.
    always_comb begin
        write_ready = (state == IDLE);
        resp_valid  = (state == RESP);
    end

    // Latch the SHAPE/OPERATION fields of the accepted write for the CHECK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_shape_field     <= 2'b00;
            pend_operation_field <= 6'h00;
        end else if (state == IDLE && write_valid) begin
            pend_shape_field     <= write_data[17:16];
            pend_operation_field <= write_data[5:0];
        end
    end

    // Commit or reject the pending write at the end of CHECK, all-or-nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            shape_q     <= RESET_SHAPE;
            operation_q <= RESET_OPERATION;
            resp_error  <= 1'b0;
            err_count   <= '0;
        end else if (state == CHECK) begin
            resp_error <= reject;
            if (reject) begin
                if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
            end else begin
                shape_q     <= new_shape;
                operation_q <= new_operation;
            end
        end
    end

    // Architectural CTRL image with reserved bits forced to zero.
    always_comb begin
        ctrl_word           = '0;
        ctrl_word.shape     = shape_e'(shape_q);
        ctrl_word.operation = operation_e'(operation_q);
    end

    // Read port: snapshot the current CTRL word one cycle after the request, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_valid <= 1'b0;
            read_data       <= 32'h0;
        end else begin
            read_data_valid <= read_valid;
            if (read_valid) read_data <= ctrl_word;
        end
    end

    assign shape     = shape_q;
    assign operation = operation_q;

endmodule

// File: doc/shape_processor_ctrl_sfr.md
Name: shape_processor_ctrl_sfr

Overview:
Responder side of the shape processor CTRL SFR write/read interface. It accepts software writes to CTRL and resolves KEEP_SHAPE/KEEP_OPERATION against the current contents. It discards any write that yields an illegal encoding or an illegal shape/operation combination, and answers every write with an OK/ERROR response. It holds the architectural SHAPE/OPERATION state consumed by the shape processor datapath, and exposes a saturating rejected-write counter.

Parameters:
ERR_CNT_WIDTH, 8, width of the saturating rejected-write counter
RESET_SHAPE, RECTANGLE, SHAPE value after reset; must be RECTANGLE or TRIANGLE
RESET_OPERATION, PERIMETER, OPERATION value after reset; RESET_SHAPE/RESET_OPERATION must form a legal combination

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
write_valid  in  1  write request
write_ready  out  1  write accepted when high together with write_valid
write_data  in  32  CTRL word: SHAPE in [17:16], OPERATION in [5:0], reserved bits elsewhere
resp_valid  out  1  write response available
resp_ready  in  1  response consumed
resp_error  out  1  1 = write rejected; valid only while resp_valid
read_valid  in  1  read request, always accepted
read_data_valid  out  1  read data strobe
read_data  out  32  CTRL word, reserved bits read 0
shape  out  2  current SHAPE, to datapath
operation  out  6  current OPERATION, to datapath
err_count  out  ERR_CNT_WIDTH  rejected writes, saturating

Behaviour:
- Reset (synchronous, active-high, one cycle) gives: FSM=IDLE, shape=RESET_SHAPE, operation=RESET_OPERATION, write_ready=1, resp_valid=0, resp_error=0, read_data_valid=0, read_data=0, err_count=0.
- FSM has three states: IDLE, CHECK, RESP.
- IDLE: write_ready=1. On write_valid, latch write_data and go to CHECK. write_ready=0 in all other states.
- CHECK (one cycle), field decode:
  - new_shape = old shape if SHAPE==KEEP_SHAPE, else the SHAPE field.
  - new_operation = old operation if OPERATION==KEEP_OPERATION, else the OPERATION field.
- CHECK, reject when any of: SHAPE is an illegal encoding ('b00); OPERATION is an illegal encoding; (new_shape,new_operation) is not a legal combination. Legal combinations:
  - PERIMETER and AREA with any shape.
  - IS_SQUARE with RECTANGLE only.
  - IS_EQUILATERAL and IS_ISOSCELES with TRIANGLE only.
- CHECK outcome:
  - Reject: shape/operation unchanged (all-or-nothing, never a partial field update); err_count increments and holds at all-ones; resp_error=1.
  - Accept: shape/operation update at the end of CHECK; resp_error=0.
  - Either way, go to RESP.
- Reserved bits of write_data are ignored and never cause rejection.
- RESP: resp_valid=1; resp_error stays stable until resp_ready. Return to IDLE on the resp_ready cycle. resp_ready outside RESP is ignored.
- Write timing: handshake in cycle T; new shape/operation visible from T+2; resp_valid from T+2. Minimum write-to-write spacing is 3 cycles.
- Read timing:
  - read_valid in cycle T gives read_data_valid=1 and read_data at T+1, showing shape/operation as of cycle T.
  - A read in the CHECK cycle returns the pre-write value.
  - Reads are independent of the FSM; a read and a write in the same cycle are both served.
  - read_data is held between reads.
- rst in any state aborts the pending write (no response, no update) and restores reset values.

Decomposition:
- Shared package shape_processor_modeling, already used by the team, supplies ctrl_sfr_reg, shape_e, operation_e, is_legal_shape, is_legal_operation and is_legal_combination.
- No new package types are needed; add the FSM state enum there only if the bench references it.
- One natural sub-module: shape_processor_ctrl_resolve. It is combinational and maps (old shape, old operation, write word) to (new_shape, new_operation, reject).

Test Plan:
- After reset, read -> read_data=0x0001_0000 (RECTANGLE/PERIMETER), err_count=0.
- Write 0x0002_0020 -> resp_error=0; shape=TRIANGLE, operation=IS_EQUILATERAL at T+2; read returns 0x0002_0020.
- From TRIANGLE/IS_EQUILATERAL, write 0x0001_003F (RECTANGLE, KEEP_OPERATION) -> illegal combination, resp_error=1, state unchanged, err_count=1.
- Write 0x0003_0001 (KEEP_SHAPE, AREA) -> accepted with shape kept and operation=AREA. Then write 0xFFFC_FFC0 (reserved bits set, SHAPE=00, OPERATION=PERIMETER) -> rejected on the illegal encoding.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_error stable, write_ready=0, a second write_valid is not accepted. Drive 2^ERR_CNT_WIDTH+3 illegal writes -> err_count saturates at all-ones.
- Assert rst during CHECK of an otherwise legal write -> no response issued, shape/operation return to reset values, write_ready=1 the cycle after reset.
